mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8: word-address width of the internal store; depth 2^ADDR_W 16-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, legal 0..15: read wait states inserted before memDataReady.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 ExternalReset  input  1  reset, asynchronous, active-low.
REQ-005 Address  input  16  word address from CPU address unit; only bits [ADDR_W-1:0] used.
REQ-006 DataIn  input  16  write data from CPU operand bus.
REQ-007 ReadMem  input  1  read request level; CPU holds it high until it samples memDataReady=1.
REQ-008 WriteMem  input  1  write strobe; CPU asserts it for one cycle and never waits for a response.
REQ-009 DataOut  output  16  read data, registered.
REQ-010 memDataReady  output  1  read-complete strobe, registered, one cycle wide.
REQ-011 ProtocolErr  output  1  sticky flag, registered.

Function
REQ-012 The FSM SHALL have states IDLE, WAIT, READY, with a 4-bit down-counter WCNT.
REQ-013 IDLE, ReadMem=1 sampled at edge k: latch Address[ADDR_W-1:0] into RADDR; go to READY if WAIT_CYCLES=0, else go to WAIT with WCNT=WAIT_CYCLES-1.
REQ-014 WAIT: WCNT=0 -> READY, else WCNT decrements; memDataReady rises after edge k+WAIT_CYCLES (latency WAIT_CYCLES+1 edges from request sample to the ready cycle).
REQ-015 On the transition into READY, DataOut SHALL load mem[RADDR], and memDataReady SHALL be 1 for exactly the READY cycle.
REQ-016 READY SHALL always return to IDLE, regardless of ReadMem; a new read is accepted no earlier than the cycle after READY.
REQ-017 ReadMem=0 sampled in WAIT SHALL abort to IDLE with no memDataReady pulse and DataOut unchanged.
REQ-018 DataOut SHALL hold its value between reads; it changes only on entry to READY or on reset.
REQ-019 WriteMem=1 at any edge, in any state, SHALL write DataIn to mem[Address[ADDR_W-1:0]] at that edge; writes never assert memDataReady.
REQ-020 A write and a read-data load at the same edge to the same address SHALL return the pre-write (old) word; a write at any earlier edge SHALL be visible.
REQ-021 ReadMem=1 and WriteMem=1 both sampled in IDLE SHALL perform the write only, ignore the read that cycle, and set ProtocolErr.
REQ-022 ProtocolErr, once set, SHALL stay 1 until reset.
REQ-023 Address bits above ADDR_W-1 SHALL be ignored (address wraps modulo 2^ADDR_W).
REQ-024 Memory contents SHALL be undefined after power-up and SHALL NOT be cleared by reset.

Reset
REQ-025 ExternalReset=0 SHALL immediately force state IDLE, WCNT=0, memDataReady=0, DataOut=16'h0000, ProtocolErr=0, RADDR=0.
REQ-026 Reset asserted mid-read (WAIT or READY) SHALL abandon the read; no memDataReady pulse after reset release until a new ReadMem is sampled in IDLE.
REQ-027 A write strobe coinciding with active reset SHALL NOT modify memory.
REQ-028 The first edge after ExternalReset rises SHALL be able to sample a request in IDLE.

Verification
REQ-029 WAIT_CYCLES=2: write 16'hA5C3 to addr 8'h10; then hold ReadMem with Address=16'h0010 -> memDataReady high exactly one cycle, 2 edges after the request sample; DataOut=16'hA5C3, held afterwards.
REQ-030 WAIT_CYCLES=0: ReadMem on addr 8'h01 holding 16'h1234 -> memDataReady in the cycle immediately after the sample edge; the next request is accepted only after one IDLE cycle.
REQ-031 Address=16'h0310 with ADDR_W=8 -> reads and writes hit word 8'h10 (wrap check).
REQ-032 ReadMem and WriteMem both high in IDLE, DataIn=16'h00FF at addr 8'h20 -> mem[8'h20]=16'h00FF, no memDataReady, ProtocolErr=1 and sticky.
REQ-033 ReadMem dropped during WAIT -> no memDataReady pulse, DataOut unchanged; reset pulsed during WAIT -> all outputs 0 immediately, previously written words still readable.
REQ-034 WriteMem to addr 8'h10 (16'hBEEF) at the same edge the READY load of addr 8'h10 occurs -> DataOut=old word; a following read returns 16'hBEEF.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word store with a wait-stated read handshake and fire-and-forget writes.
// Read data is registered on entry to READY; writes land at the edge they are strobed.
module mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        ExternalReset,
  input  logic [15:0] Address,
  input  logic [15:0] DataIn,
  input  logic        ReadMem,
  input  logic        WriteMem,
  output logic [15:0] DataOut,
  output logic        memDataReady,
  output logic        ProtocolErr
);

  localparam int unsigned DEPTH        = 1 << ADDR_W;
  localparam logic [3:0]  LP_WCNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READY
  } state_t;

  state_t              r_state;
  logic [3:0]          r_wcnt;
  logic [ADDR_W-1:0]   r_raddr;
  logic [15:0]         r_dout;
  logic                r_data_ready;
  logic                r_proto_err;
  logic [15:0]         r_mem [0:DEPTH-1];
  logic [ADDR_W-1:0]   w_addr;

  assign w_addr = Address[ADDR_W-1:0];

  generate
    if (ADDR_W < 16) begin : g_addr_hi
      logic w_addr_unused;
      assign w_addr_unused = ^Address[15:ADDR_W];
    end
  endgenerate

  // Store is never cleared; a strobe during active reset is dropped.
  always_ff @(posedge clk) begin
    if (ExternalReset && WriteMem) begin
      r_mem[w_addr] <= DataIn;
    end
  end

  // Reads of r_mem here see the pre-write word when a write shares the edge.
  always_ff @(posedge clk or negedge ExternalReset) begin
    if (!ExternalReset) begin
      r_state      <= S_IDLE;
      r_wcnt       <= '0;
      r_raddr      <= '0;
      r_dout       <= '0;
      r_data_ready <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_data_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ReadMem && WriteMem) begin
            r_proto_err <= 1'b1;
          end else if (ReadMem) begin
            r_raddr <= w_addr;
            if (WAIT_CYCLES == 0) begin
              r_state      <= S_READY;
              r_dout       <= r_mem[w_addr];
              r_data_ready <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_wcnt  <= LP_WCNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!ReadMem) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
          end else if (r_wcnt == '0) begin
            r_state      <= S_READY;
            r_dout       <= r_mem[r_raddr];
            r_data_ready <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        S_READY: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_wcnt  <= '0;
        end
      endcase
    end
  end

  assign DataOut      = r_dout;
  assign memDataReady = r_data_ready;
  assign ProtocolErr  = r_proto_err;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: expected read words queued at request time, popped on memDataReady.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] a2, d2, q2, a0, d0, q0;
  logic        rd2, wr2, rdy2, perr2, rd0, wr0, rdy0, perr0;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .ExternalReset(rst_n), .Address(a2), .DataIn(d2),
    .ReadMem(rd2), .WriteMem(wr2), .DataOut(q2), .memDataReady(rdy2), .ProtocolErr(perr2)
  );

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .ExternalReset(rst_n), .Address(a0), .DataIn(d0),
    .ReadMem(rd0), .WriteMem(wr0), .DataOut(q0), .memDataReady(rdy0), .ProtocolErr(perr0)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] model [0:255];
  logic [15:0] sb_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every ready pulse from the wait-stated instance must match the oldest queued word.
  always begin
    @(posedge clk);
    #1;
    if (rdy2 === 1'b1) begin
      if (sb_q.size() == 0) check_eq("rdy2_unexpected", {31'd0, rdy2}, 32'd0);
      else check_eq("rd2_data", {16'd0, q2}, {16'd0, sb_q.pop_front()});
    end
  end

  task automatic write2(input logic [15:0] addr, input logic [15:0] data);
    a2 = addr; d2 = data; wr2 = 1'b1;
    tick();
    wr2 = 1'b0;
    model[addr[7:0]] = data;
    check_eq("wr2_no_rdy", {31'd0, rdy2}, 32'd0);
  endtask

  task automatic read2(input logic [15:0] addr);
    int unsigned lat;
    logic seen;
    sb_q.push_back(model[addr[7:0]]);
    a2 = addr; rd2 = 1'b1; lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      tick();
      lat++;
      if (rdy2 === 1'b1) seen = 1'b1;
    end
    rd2 = 1'b0;
    check_eq("rd2_latency", lat, 32'd3);
    if (!seen) void'(sb_q.pop_back());
    tick();
    check_eq("rd2_pulse_width", {31'd0, rdy2}, 32'd0);
    check_eq("rd2_hold", {16'd0, q2}, {16'd0, model[addr[7:0]]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] old;
    logic [15:0] pat_a [0:5];
    logic [15:0] pat_d [0:5];
    a2 = '0; d2 = '0; rd2 = 1'b0; wr2 = 1'b0;
    a0 = '0; d0 = '0; rd0 = 1'b0; wr0 = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick(); tick();
    check_eq("rst_dout2", {16'd0, q2}, 32'd0);
    check_eq("rst_rdy2", {31'd0, rdy2}, 32'd0);
    check_eq("rst_perr2", {31'd0, perr2}, 32'd0);
    check_eq("rst_dout0", {16'd0, q0}, 32'd0);
    check_eq("rst_rdy0", {31'd0, rdy0}, 32'd0);
    rst_n = 1'b1;
    tick();

    write2(16'h0010, 16'hA5C3);
    read2(16'h0010);
    repeat (3) begin
      tick();
      check_eq("dout_held", {16'd0, q2}, 32'h0000A5C3);
    end

    write2(16'h0310, 16'h1111);
    read2(16'h0010);
    write2(16'h0010, 16'h2222);
    read2(16'hFF10);

    for (int i = 0; i < 6; i++) begin
      pat_a[i] = 16'($urandom);
      pat_d[i] = 16'($urandom);
      write2(pat_a[i], pat_d[i]);
    end
    for (int i = 0; i < 6; i++) read2(pat_a[i] ^ 16'h5A00);

    old = q2;
    a2 = 16'h0010; rd2 = 1'b1;
    tick();
    rd2 = 1'b0;
    repeat (5) begin
      tick();
      check_eq("abort_no_rdy", {31'd0, rdy2}, 32'd0);
      check_eq("abort_dout", {16'd0, q2}, {16'd0, old});
    end

    check_eq("perr_clear", {31'd0, perr2}, 32'd0);
    a2 = 16'h0020; d2 = 16'h00FF; rd2 = 1'b1; wr2 = 1'b1;
    tick();
    rd2 = 1'b0; wr2 = 1'b0;
    model[8'h20] = 16'h00FF;
    check_eq("perr_set", {31'd0, perr2}, 32'd1);
    repeat (4) begin
      tick();
      check_eq("perr_no_rdy", {31'd0, rdy2}, 32'd0);
    end
    read2(16'h0020);
    check_eq("perr_sticky", {31'd0, perr2}, 32'd1);

    old = model[8'h10];
    sb_q.push_back(old);
    a2 = 16'h0010; rd2 = 1'b1;
    tick(); tick();
    wr2 = 1'b1; d2 = 16'hBEEF;
    tick();
    wr2 = 1'b0; rd2 = 1'b0;
    check_eq("coll_rdy", {31'd0, rdy2}, 32'd1);
    check_eq("coll_old", {16'd0, q2}, {16'd0, old});
    model[8'h10] = 16'hBEEF;
    tick();
    read2(16'h0010);

    a0 = 16'h0001; d0 = 16'h1234; wr0 = 1'b1;
    tick();
    wr0 = 1'b0;
    check_eq("w0_no_rdy", {31'd0, rdy0}, 32'd0);
    a0 = 16'h0101; rd0 = 1'b1;
    tick();
    check_eq("r0_latency", {31'd0, rdy0}, 32'd1);
    check_eq("r0_data", {16'd0, q0}, 32'h00001234);
    tick();
    check_eq("r0_idle_gap", {31'd0, rdy0}, 32'd0);
    tick();
    check_eq("r0_reaccept", {31'd0, rdy0}, 32'd1);
    rd0 = 1'b0;
    tick();
    check_eq("r0_pulse_width", {31'd0, rdy0}, 32'd0);
    check_eq("r0_hold", {16'd0, q0}, 32'h00001234);

    a2 = 16'h0010; rd2 = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_dout", {16'd0, q2}, 32'd0);
    check_eq("midrst_rdy", {31'd0, rdy2}, 32'd0);
    check_eq("midrst_perr", {31'd0, perr2}, 32'd0);
    check_eq("midrst_dout0", {16'd0, q0}, 32'd0);
    rd2 = 1'b0; wr2 = 1'b1; d2 = 16'hDEAD;
    tick();
    wr2 = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      check_eq("postrst_no_rdy", {31'd0, rdy2}, 32'd0);
    end
    read2(16'h0010);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    read2(16'h0020);
    check_eq("postrst_perr", {31'd0, perr2}, 32'd0);

    tick(); tick();
    check_eq("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
